pl_gpio_irq_axil: RTL and testbench

Parametrised AXI4-Lite GPIO slave, the successor to the fixed 4-register pl_gpio. It adds:
- per-bit direction control;
- a synchronised input path;
- atomic set/clear of the output register;
- per-bit rising/falling edge capture into a write-1-to-clear status register;
- a level interrupt output for the PS interrupt controller.

It sits behind the PS AXI interconnect and drives the CNC I/O pins via IOBUFs.

---
 rtl/pl_gpio_irq_axil.sv | 204 ++++++++++++++++++++
 tb/tb_pl_gpio_irq_axil.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_gpio_irq_axil.sv
// pl_gpio_irq_axil: AXI4-Lite GPIO slave with per-bit direction, synchronised
// inputs, atomic set/clear of OUT, edge capture into a W1C STATUS register and
// a registered level interrupt.
//
// Ports:
//   s00_axi_*  AXI4-Lite slave (single clock, async active-high reset)
//   gpio_i     asynchronous pin inputs
//   gpio_o     pin outputs (OUT register)
//   gpio_t     tristate control, 1 = input (~DIR)
//   irq        level interrupt, registered OR of STATUS
//
// Register map (word index = addr[4:2]):
//   0 OUT  1 DIR  2 IN(RO)  3 RISE_EN  4 FALL_EN  5 STATUS(W1C)
//   6 OUT_SET(WO)  7 OUT_CLR(WO)

// Per-bit input lane: synchroniser, previous-value flop, edge detect and the
// sticky STATUS bit.
module pl_gpio_irq_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  input  logic rise_en_i,
  input  logic fall_en_i,
  input  logic w1c_i,
  output logic in_o,
  output logic status_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q, status_q, status_d;

  assign in_o     = sync_q[SYNC_STAGES-1];
  assign status_o = status_q;

  // A new edge in the same cycle as a W1C keeps the bit set.
  assign status_d = (status_q & ~w1c_i)
                  | (in_o & ~prev_q & rise_en_i)
                  | (~in_o & prev_q & fall_en_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q   <= in_o;
      status_q <= status_d;
    end
  end
endmodule

module pl_gpio_irq_axil #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 5,
  parameter int GPIO_WIDTH           = 32,
  parameter int SYNC_STAGES          = 2
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic [GPIO_WIDTH-1:0]             gpio_i,
  output logic [GPIO_WIDTH-1:0]             gpio_o,
  output logic [GPIO_WIDTH-1:0]             gpio_t,
  output logic                              irq
);
  localparam int DW = C_S00_AXI_DATA_WIDTH;

  logic awready_q, wready_q, bvalid_q, arready_q, rvalid_q, irq_q;
  logic [DW-1:0] rdata_q, rd_mux;
  logic [GPIO_WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q;
  logic [GPIO_WIDTH-1:0] out_d, dir_d, rise_en_d, fall_en_d, w1c;
  logic [GPIO_WIDTH-1:0] in_w, status_w, wmask, wdat;
  logic [DW-1:0] strb_mask;
  logic wr_en, wr_hs, ar_en, ar_hs;

  // Accept only when both AW and W are present; the ready pulse itself is
  // the handshake cycle, so the register update lands on that edge.
  assign wr_en = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awready_q;
  assign wr_hs = awready_q & s00_axi_awvalid & wready_q & s00_axi_wvalid;
  assign ar_en = s00_axi_arvalid & ~rvalid_q & ~arready_q;
  assign ar_hs = arready_q & s00_axi_arvalid;

  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < DW/8; b++) strb_mask[b*8 +: 8] = {8{s00_axi_wstrb[b]}};
  end
  assign wmask = strb_mask[GPIO_WIDTH-1:0];
  assign wdat  = s00_axi_wdata[GPIO_WIDTH-1:0] & wmask;

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wr_hs) begin
      case (s00_axi_awaddr[4:2])
        3'd0:    out_d     = (out_q & ~wmask) | wdat;
        3'd1:    dir_d     = (dir_q & ~wmask) | wdat;
        3'd3:    rise_en_d = (rise_en_q & ~wmask) | wdat;
        3'd4:    fall_en_d = (fall_en_q & ~wmask) | wdat;
        3'd5:    w1c       = wdat;
        3'd6:    out_d     = out_q | wdat;
        3'd7:    out_d     = out_q & ~wdat;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s00_axi_araddr[4:2])
      3'd0:    rd_mux[GPIO_WIDTH-1:0] = out_q;
      3'd1:    rd_mux[GPIO_WIDTH-1:0] = dir_q;
      3'd2:    rd_mux[GPIO_WIDTH-1:0] = in_w;
      3'd3:    rd_mux[GPIO_WIDTH-1:0] = rise_en_q;
      3'd4:    rd_mux[GPIO_WIDTH-1:0] = fall_en_q;
      3'd5:    rd_mux[GPIO_WIDTH-1:0] = status_w;
      default: rd_mux = '0;
    endcase
  end

  for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_lane
    pl_gpio_irq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk_i    (s00_axi_aclk),
      .rst_i    (s00_axi_areset),
      .pin_i    (gpio_i[g]),
      .rise_en_i(rise_en_q[g]),
      .fall_en_i(fall_en_q[g]),
      .w1c_i    (w1c[g]),
      .in_o     (in_w[g]),
      .status_o (status_w[g])
    );
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      awready_q <= wr_en;
      wready_q  <= wr_en;
      if (wr_hs)               bvalid_q <= 1'b1;
      else if (s00_axi_bready) bvalid_q <= 1'b0;
      arready_q <= ar_en;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      irq_q     <= |status_w;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign gpio_o          = out_q;
  assign gpio_t          = ~dir_q;
  assign irq             = irq_q;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                       s00_axi_araddr[1:0], s00_axi_wdata, strb_mask};
endmodule

// File: tb/tb_pl_gpio_irq_axil.sv
module tb_pl_gpio_irq_axil;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot = 3'b000, arprot = 3'b000;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, gpio_i, gpio_o, gpio_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pl_gpio_irq_axil dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t),
    .irq(irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives AW+W until the ready pulse, then returns just after the commit edge.
  task automatic write_start(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    do begin tick(); n++; end while (!awready && n < 20);
    chk("aw_accept", {31'd0, awready}, 32'd1);
    chk("w_with_aw", {31'd0, wready}, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_rise", {31'd0, bvalid}, 32'd1);
  endtask

  task automatic write_resp();
    chk("bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_drop", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    write_start(a, d, s);
    write_resp();
  endtask

  task automatic read_start(input logic [4:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    do begin tick(); n++; end while (!arready && n < 20);
    chk("ar_accept", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    chk("rvalid_rise", {31'd0, rvalid}, 32'd1);
    d = rdata;
  endtask

  task automatic read_resp();
    chk("rresp", {30'd0, rresp}, 32'd0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_drop", {31'd0, rvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    read_start(a, d);
    read_resp();
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic [31:0] exp_o;
    logic [31:0] exp_t;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    rst = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    gpio_i = '0;

    // Reset reads, then register-map traffic with expected pin state after each op.
    for (int i = 0; i < 8; i++)
      vecs.push_back('{0, 5'(i*4), 32'h0, 4'h0, 32'h0, 32'h0, 32'hFFFFFFFF});
    vecs.push_back('{1, 5'h04, 32'h0000FFFF, 4'hF, 32'h0, 32'h00000000, 32'hFFFF0000});
    vecs.push_back('{1, 5'h00, 32'h000000A5, 4'hF, 32'h0, 32'h000000A5, 32'hFFFF0000});
    vecs.push_back('{1, 5'h18, 32'h00000F00, 4'hF, 32'h0, 32'h00000FA5, 32'hFFFF0000});
    vecs.push_back('{1, 5'h1C, 32'h00000005, 4'hF, 32'h0, 32'h00000FA0, 32'hFFFF0000});
    vecs.push_back('{0, 5'h00, 32'h0,        4'h0, 32'h00000FA0, 32'h00000FA0, 32'hFFFF0000});
    vecs.push_back('{0, 5'h04, 32'h0,        4'h0, 32'h0000FFFF, 32'h00000FA0, 32'hFFFF0000});
    vecs.push_back('{1, 5'h1C, 32'hFFFFFFFF, 4'hF, 32'h0, 32'h00000000, 32'hFFFF0000});
    vecs.push_back('{1, 5'h00, 32'hFFFFFFFF, 4'h2, 32'h0, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{0, 5'h00, 32'h0,        4'h0, 32'h0000FF00, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{1, 5'h08, 32'h12345678, 4'hF, 32'h0, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{0, 5'h08, 32'h0,        4'h0, 32'h00000000, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{1, 5'h0C, 32'hFFFFFFFF, 4'h1, 32'h0, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{0, 5'h0C, 32'h0,        4'h0, 32'h000000FF, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{1, 5'h18, 32'hFFFFFFFF, 4'h8, 32'h0, 32'hFF00FF00, 32'hFFFF0000});
    vecs.push_back('{1, 5'h1C, 32'hFFFFFFFF, 4'h8, 32'h0, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{1, 5'h14, 32'hFFFFFFFF, 4'hF, 32'h0, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{0, 5'h14, 32'h0,        4'h0, 32'h00000000, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{0, 5'h18, 32'h0,        4'h0, 32'h00000000, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{0, 5'h1C, 32'h0,        4'h0, 32'h00000000, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{1, 5'h0C, 32'h00000001, 4'hF, 32'h0, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{0, 5'h0C, 32'h0,        4'h0, 32'h00000001, 32'h0000FF00, 32'hFFFF0000});
    vecs.push_back('{1, 5'h04, 32'hFFFFFFFF, 4'h4, 32'h0, 32'h0000FF00, 32'hFF000000});
    vecs.push_back('{1, 5'h04, 32'h00000000, 4'hF, 32'h0, 32'h0000FF00, 32'hFFFFFFFF});
    vecs.push_back('{1, 5'h00, 32'h00000000, 4'hF, 32'h0, 32'h00000000, 32'hFFFFFFFF});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_t", gpio_t, 32'hFFFFFFFF);
    chk("rst_gpio_o", gpio_o, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_hs", {28'd0, awready, wready, arready, bvalid | rvalid}, 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      else begin
        axi_read(vecs[i].addr, rd);
        chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
      end
      chk($sformatf("v%0d gpio_o", i), gpio_o, vecs[i].exp_o);
      chk($sformatf("v%0d gpio_t", i), gpio_t, vecs[i].exp_t);
    end

    // Rising edge on bit 0: STATUS on the 3rd edge, irq on the 4th.
    tick();
    gpio_i[0] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("rise irq edge%0d", e), {31'd0, irq}, (e == 4) ? 32'd1 : 32'd0);
    end
    axi_read(5'h14, rd);
    chk("rise status", rd, 32'h1);
    write_start(5'h14, 32'h1, 4'hF);
    chk("w1c irq at hs", {31'd0, irq}, 32'd1);
    write_resp();
    chk("w1c irq after", {31'd0, irq}, 32'd0);
    axi_read(5'h14, rd);
    chk("w1c status", rd, 32'h0);

    // Falling edge on bit 1 that lands on the same edge as a W1C of bit 1.
    axi_write(5'h10, 32'h2, 4'hF);
    gpio_i[1] = 1'b1;
    repeat (5) tick();
    gpio_i[1] = 1'b0;
    repeat (5) tick();
    chk("fall irq", {31'd0, irq}, 32'd1);
    axi_read(5'h14, rd);
    chk("fall status", rd, 32'h2);
    gpio_i[1] = 1'b1;
    repeat (5) tick();
    gpio_i[1] = 1'b0;
    tick();
    write_start(5'h14, 32'h2, 4'hF);
    chk("collide irq hs", {31'd0, irq}, 32'd1);
    write_resp();
    chk("collide irq +1", {31'd0, irq}, 32'd1);
    tick();
    chk("collide irq +2", {31'd0, irq}, 32'd1);
    axi_read(5'h14, rd);
    chk("collide status", rd, 32'h2);
    axi_write(5'h14, 32'h2, 4'hF);
    chk("clear irq", {31'd0, irq}, 32'd0);

    // Enabling a pin that is already high must not raise STATUS.
    gpio_i[2] = 1'b1;
    repeat (5) tick();
    axi_write(5'h0C, 32'h5, 4'hF);
    repeat (3) tick();
    axi_read(5'h14, rd);
    chk("no retro status", rd, 32'h0);
    chk("no retro irq", {31'd0, irq}, 32'd0);

    // Back-pressure: responses held, second requests must wait, then async reset.
    write_start(5'h00, 32'h11, 4'hF);
    read_start(5'h00, rd);
    chk("hold rd0", rd, 32'h11);
    awaddr = 5'h04; wdata = 32'h22; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h04; arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold%0d readys", i), {29'd0, awready, wready, arready}, 32'd0);
      chk($sformatf("hold%0d valids", i), {30'd0, bvalid, rvalid}, 32'd3);
      chk($sformatf("hold%0d rdata", i), rdata, 32'h11);
      chk($sformatf("hold%0d gpio_o", i), gpio_o, 32'h11);
      if (i == 5) begin
        #3 rst = 1'b1;
        #1;
        chk("arst valids", {30'd0, bvalid, rvalid}, 32'd0);
        chk("arst readys", {29'd0, awready, wready, arready}, 32'd0);
        chk("arst rdata", rdata, 32'h0);
        chk("arst gpio_o", gpio_o, 32'h0);
        chk("arst gpio_t", gpio_t, 32'hFFFFFFFF);
        chk("arst irq", {31'd0, irq}, 32'd0);
        break;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("post rst irq", {31'd0, irq}, 32'd0);
    chk("post rst valids", {30'd0, bvalid, rvalid}, 32'd0);
    axi_read(5'h14, rd);
    chk("post rst status", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
